// File: rtl/cmp_sweep_driver_pkg.sv
// Shared definitions for the comparator sweep driver.
//  - state_t : FSM encodings (IDLE/RUN/DRAIN/DONE)
//  - MODE_*  : reference-model selection
//  - LAT_MAX : largest supported comparator latency
package cmp_sweep_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;
  localparam int LAT_MAX       = 8;

endpackage

// File: rtl/cmp_delay_line.sv
// Fixed-latency delay line for sweep scoreboard entries.
//  Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset; clears the valid bits only
//   din    in  W bits, {valid, payload}; pushed every cycle
//   dout   out W bits, entry pushed DEPTH cycles earlier
module cmp_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0]          vld_pipe;
  logic [DEPTH-1:0]          vld_nxt;
  logic [DEPTH-1:0][W-2:0]   dat_pipe;
  logic [DEPTH-1:0][W-2:0]   dat_nxt;

  always_comb begin
    vld_nxt    = vld_pipe;
    dat_nxt    = dat_pipe;
    vld_nxt[0] = din[W-1];
    dat_nxt[0] = din[W-2:0];
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i] = vld_pipe[i-1];
      dat_nxt[i] = dat_pipe[i-1];
    end
  end

  // Payload needs no reset: a cleared valid bit masks whatever it carries.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= vld_nxt;
    dat_pipe <= dat_nxt;
  end

  assign dout = {vld_pipe[DEPTH-1], dat_pipe[DEPTH-1]};

endmodule

// File: rtl/cmp_sweep_driver.sv
// Exhaustive sweep driver for an a<b comparator.
//  On start, walks every (a,b) pair (a outer, b inner), one per clock, and
//  checks the comparator result c, returned LAT cycles later, against a
//  signed or unsigned reference model.
//  Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                1-cycle pulse, honoured in IDLE or DONE
//   a, b                 operands driven to the comparator
//   c                    comparator result for the pair driven LAT cycles ago
//   busy, done           RUN/DRAIN, DONE status
//   hit_count            number of sampled c==1
//   err_count            number of samples where c differs from the model
//   first_err_a/b        operands of the first mismatch of the run (0 if none)
//  LAT must be within 1..LAT_MAX.
module cmp_sweep_driver
  import cmp_sweep_driver_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAT   = 1,
  parameter int MODE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic               c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   hit_count,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int CW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;

  state_t         state;
  logic           err_seen;
  logic [3:0]     drain_cnt;
  logic           exp_lt;
  logic           last_pair;
  logic [EW-1:0]  dl_in;
  logic [EW-1:0]  dl_out;
  logic           s_vld;
  logic           s_exp;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;

  // Reference model on the pair being driven this cycle.
  always_comb begin
    if (MODE == MODE_SIGNED) exp_lt = $signed(a) < $signed(b);
    else                     exp_lt = a < b;
  end

  assign last_pair = (a == '1) && (b == '1);

  // Only RUN cycles carry a real pair; everything else is pushed as a bubble.
  assign dl_in = {(state == RUN), exp_lt, a, b};

  cmp_delay_line #(
    .DEPTH (LAT),
    .W     (EW)
  ) u_dl (
    .clk   (clk),
    .reset (reset),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign {s_vld, s_exp, s_a, s_b} = dl_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit_count   <= '0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      err_seen    <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            a           <= '0;
            b           <= '0;
            hit_count   <= '0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            err_seen    <= 1'b0;
          end
        end
        RUN: begin
          // Operands stay on the last pair through DRAIN and DONE.
          if (last_pair) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            b <= b + 1'b1;
            if (b == '1) a <= a + 1'b1;
          end
        end
        DRAIN: begin
          // LAT+1 drain cycles: the last real entry is sampled on the
          // LAT-th, DONE registers on the following edge.
          if (drain_cnt == 4'(LAT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Result sampling; the cases above never touch the accumulators in
      // RUN/DRAIN, so there is no conflict with the start-time clear.
      if ((state == RUN || state == DRAIN) && s_vld) begin
        if (c) hit_count <= hit_count + CW'(1);
        if (c != s_exp) begin
          err_count <= err_count + CW'(1);
          if (!err_seen) begin
            err_seen    <= 1'b1;
            first_err_a <= s_a;
            first_err_b <= s_b;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_sweep_driver.sv
module tb_cmp_sweep_driver;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, start, stuck;
  always #5 clk = ~clk;

  // DUT 1: LAT=1 signed; DUT 3: LAT=3 signed; DUT 0: LAT=1 unsigned model
  logic [W-1:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3, a0, b0, fa0, fb0;
  logic [2*W:0] hit1, err1, hit3, err3, hit0, err0;
  logic busy1, done1, busy3, done3, busy0, done0;
  logic c1, c0;
  logic [2:0] c3p;

  cmp_sweep_driver #(.WIDTH(W), .LAT(1), .MODE(1)) d1 (
    .clk(clk), .reset(reset), .start(start), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .hit_count(hit1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1));
  cmp_sweep_driver #(.WIDTH(W), .LAT(3), .MODE(1)) d3 (
    .clk(clk), .reset(reset), .start(start), .a(a3), .b(b3), .c(c3p[2]),
    .busy(busy3), .done(done3), .hit_count(hit3), .err_count(err3),
    .first_err_a(fa3), .first_err_b(fb3));
  cmp_sweep_driver #(.WIDTH(W), .LAT(1), .MODE(0)) d0 (
    .clk(clk), .reset(reset), .start(start), .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .hit_count(hit0), .err_count(err0),
    .first_err_a(fa0), .first_err_b(fb0));

  // Comparator models: all signed; d1's can be forced stuck at 0.
  always_ff @(posedge clk) begin
    c1  <= stuck ? 1'b0 : ($signed(a1) < $signed(b1));
    c0  <= $signed(a0) < $signed(b0);
    c3p <= {c3p[1:0], ($signed(a3) < $signed(b3))};
  end

  typedef struct {
    int hit;
    int err;
    int fa;
    int fb;
    int dn;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t q0[$];

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit stuck_run);
    exp_t e;
    if (stuck_run) e = '{hit: 0, err: 120, fa: 0, fb: 1, dn: 258};
    else           e = '{hit: 120, err: 0, fa: 0, fb: 0, dn: 258};
    q1.push_back(e);
    q3.push_back('{hit: 120, err: 0, fa: 0, fb: 0, dn: 260});
    q0.push_back('{hit: 120, err: 128, fa: 0, fb: 8, dn: 258});
  endtask

  // Pulse start; returns #1 after the accepting edge E.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy1, 1);
    chk("start_done", done1, 0);
    chk("start_a", a1, 0);
    chk("start_b", b1, 0);
    chk("start_hit", hit1, 0);
    chk("start_err", err1, 0);
  endtask

  // Waits for all three done flags (bounded), optionally pulsing start
  // mid-run, then pops and compares the scoreboard.
  task automatic wait_done(input int mid);
    int n1 = -1, n3 = -1, n0 = -1;
    exp_t e;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == mid) start = 1'b1;
      if (n == mid + 1) start = 1'b0;
      if (n1 < 0 && done1) n1 = n;
      if (n3 < 0 && done3) n3 = n;
      if (n0 < 0 && done0) n0 = n;
      if (n1 >= 0 && n3 >= 0 && n0 >= 0) break;
    end
    start = 1'b0;
    e = q1.pop_front();
    chk("d1_done_time", n1, e.dn);
    chk("d1_hit", hit1, e.hit);
    chk("d1_err", err1, e.err);
    chk("d1_first_a", fa1, e.fa);
    chk("d1_first_b", fb1, e.fb);
    e = q3.pop_front();
    chk("d3_done_time", n3, e.dn);
    chk("d3_hit", hit3, e.hit);
    chk("d3_err", err3, e.err);
    chk("d3_first_a", fa3, e.fa);
    chk("d3_first_b", fb3, e.fb);
    e = q0.pop_front();
    chk("d0_done_time", n0, e.dn);
    chk("d0_hit", hit0, e.hit);
    chk("d0_err", err0, e.err);
    chk("d0_first_a", fa0, e.fa);
    chk("d0_first_b", fb0, e.fb);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, a1, 0);
    chk({tag, "_b"}, b1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_hit"}, hit1, 0);
    chk({tag, "_err"}, err1, 0);
    chk({tag, "_fa"}, fa1, 0);
    chk({tag, "_fb"}, fb1, 0);
    chk({tag, "_busy3"}, busy3, 0);
    chk({tag, "_hit3"}, hit3, 0);
    chk({tag, "_err0"}, err0, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // T1/T3/T4 together, with an ignored start pulse in the middle of RUN.
    push_exp(1'b0);
    pulse_start();
    wait_done(100);

    // DONE holds results and the last pair.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", done1, 1);
    chk("hold_busy", busy1, 0);
    chk("hold_a", a1, 15);
    chk("hold_b", b1, 15);
    chk("hold_hit", hit1, 120);

    // T2 with restart from DONE.
    stuck = 1'b1;
    push_exp(1'b1);
    pulse_start();
    wait_done(0);

    // T5: reset mid-run, then a clean run.
    stuck = 1'b0;
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("midreset");
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_hit", hit1, 0);
    chk("post_reset_err", err0, 0);
    push_exp(1'b0);
    pulse_start();
    wait_done(0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
